// File: rtl/bus_drive_ctrl.sv
// Bus source/destination controller: encodes a one-hot source request into the
// 5-bit bus select, holds it for a settle window, then strobes destination loads.
module bus_drive_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req,
    input  logic [23:0]      src_out,
    input  logic [23:0]      dst_in,
    output logic             ready,
    output logic [4:0]       select,
    output logic             bus_drive,
    output logic [23:0]      load_en,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  settleCnt;
    logic [23:0] dstMask;
    logic [4:0]  srcCode;
    logic [4:0]  codeTerm [24];
    logic        srcOneHot;
    logic        reqLegal;

    // Each source bit contributes its own index; a legal request has only one.
    for (genvar gi = 0; gi < 24; gi++) begin : g_code
        assign codeTerm[gi] = src_out[gi] ? 5'(gi) : 5'd0;
    end

    always_comb begin
        srcCode = 5'd0;
        for (int i = 0; i < 24; i++) begin
            srcCode = srcCode | codeTerm[i];
        end
    end

    // InPort and C_sign_extended are read-only, so they may never be loaded.
    assign srcOneHot = (src_out != 24'd0) && ((src_out & (src_out - 24'd1)) == 24'd0);
    assign reqLegal  = srcOneHot && (dst_in != 24'd0) && (dst_in[23:22] == 2'b00);

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= IDLE;
            settleCnt  <= 4'd0;
            dstMask    <= 24'd0;
            ready      <= 1'b0;
            select     <= 5'd0;
            bus_drive  <= 1'b0;
            load_en    <= 24'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            load_en <= 24'd0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (req && ready) begin
                        if (reqLegal) begin
                            state     <= DRIVE;
                            select    <= srcCode;
                            bus_drive <= 1'b1;
                            ready     <= 1'b0;
                            dstMask   <= dst_in;
                            settleCnt <= SETTLE_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (settleCnt == 4'd0) begin
                        state   <= LOAD;
                        load_en <= dstMask;
                        done    <= 1'b1;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                LOAD: begin
                    state      <= IDLE;
                    bus_drive  <= 1'b0;
                    ready      <= 1'b1;
                    xfer_count <= xfer_count + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_drive_ctrl.sv
// Bench for bus_drive_ctrl: one instance with a 1-cycle settle window and one
// with a 3-cycle window; completed transfers are matched against a scoreboard.
module tb_bus_drive_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        req1, req3;
    logic [23:0] src1, dst1, src3, dst3;
    logic        ready1, busDrive1, done1, err1;
    logic        ready3, busDrive3, done3, err3;
    logic [4:0]  select1, select3;
    logic [23:0] loadEn1, loadEn3;
    logic [15:0] count1, count3;

    typedef struct packed {
        logic [4:0]  sel;
        logic [23:0] mask;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1, e3;

    int testsRun  = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    bus_drive_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
        .clock(clock), .clear(clear), .req(req1), .src_out(src1), .dst_in(dst1),
        .ready(ready1), .select(select1), .bus_drive(busDrive1), .load_en(loadEn1),
        .done(done1), .err(err1), .xfer_count(count1)
    );

    bus_drive_ctrl #(.SETTLE_CYCLES(3), .CNT_W(16)) dut3 (
        .clock(clock), .clear(clear), .req(req3), .src_out(src3), .dst_in(dst3),
        .ready(ready3), .select(select3), .bus_drive(busDrive3), .load_en(loadEn3),
        .done(done3), .err(err3), .xfer_count(count3)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every load strobe must match the oldest accepted transfer.
    always @(negedge clock) begin
        if (done1) begin
            if (sb1.size() == 0) begin
                checkEq("sb1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                checkEq("sb1_select", 32'(select1), 32'(e1.sel));
                checkEq("sb1_load_en", 32'(loadEn1), 32'(e1.mask));
            end
        end
        if (done3) begin
            if (sb3.size() == 0) begin
                checkEq("sb3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e3 = sb3.pop_front();
                checkEq("sb3_select", 32'(select3), 32'(e3.sel));
                checkEq("sb3_load_en", 32'(loadEn3), 32'(e3.mask));
            end
        end
    end

    logic [23:0] rejSrc [3];
    logic [23:0] rejDst [3];

    initial begin
        rejSrc[0] = 24'h000003; rejDst[0] = 24'h000001;
        rejSrc[1] = 24'h000020; rejDst[1] = 24'h800000;
        rejSrc[2] = 24'h000020; rejDst[2] = 24'h000000;

        clear = 1'b1;
        req1 = 1'b0; src1 = '0; dst1 = '0;
        req3 = 1'b0; src3 = '0; dst3 = '0;
        tick();
        tick();
        checkEq("rst_ready", 32'(ready1), 32'd0);
        checkEq("rst_outputs", {select1, busDrive1, done1, err1}, 32'd0);
        checkEq("rst_load_en", 32'(loadEn1), 32'd0);
        checkEq("rst_count", 32'(count1), 32'd0);
        clear = 1'b0;
        tick();
        checkEq("ready_after_clear", 32'(ready1), 32'd1);
        checkEq("ready3_after_clear", 32'(ready3), 32'd1);

        // PC -> MDR with a one-cycle settle window
        req1 = 1'b1; src1 = 24'h1 << 20; dst1 = 24'h1 << 21;
        sb1.push_back('{sel: 5'd20, mask: 24'h200000});
        tick();
        req1 = 1'b0;
        checkEq("pc_select", 32'(select1), 32'd20);
        checkEq("pc_bus_drive", 32'(busDrive1), 32'd1);
        checkEq("pc_ready_low", 32'(ready1), 32'd0);
        checkEq("pc_no_done_yet", 32'(done1), 32'd0);
        tick();
        checkEq("pc_load_en", 32'(loadEn1), 32'h200000);
        checkEq("pc_done", 32'(done1), 32'd1);
        checkEq("pc_bus_in_load", 32'(busDrive1), 32'd1);
        tick();
        checkEq("pc_ready_back", 32'(ready1), 32'd1);
        checkEq("pc_count", 32'(count1), 32'd1);
        checkEq("pc_idle_outputs", {busDrive1, done1, loadEn1}, 32'd0);
        checkEq("pc_select_retained", 32'(select1), 32'd20);

        // Illegal requests: two-hot source, read-only destination, empty destination
        for (int i = 0; i < 3; i++) begin
            req1 = 1'b1; src1 = rejSrc[i]; dst1 = rejDst[i];
            tick();
            req1 = 1'b0;
            checkEq($sformatf("rej%0d_err", i), 32'(err1), 32'd1);
            checkEq($sformatf("rej%0d_bus", i), 32'(busDrive1), 32'd0);
            checkEq($sformatf("rej%0d_ready", i), 32'(ready1), 32'd1);
            checkEq($sformatf("rej%0d_select", i), 32'(select1), 32'd20);
            tick();
            checkEq($sformatf("rej%0d_err_clear", i), 32'(err1), 32'd0);
            checkEq($sformatf("rej%0d_count", i), 32'(count1), 32'd1);
        end

        // Abort during DRIVE: no load strobe may follow
        req1 = 1'b1; src1 = 24'h1 << 4; dst1 = 24'h1 << 6;
        tick();
        req1 = 1'b0;
        checkEq("abort_in_drive", 32'(busDrive1), 32'd1);
        clear = 1'b1;
        tick();
        checkEq("abort_outputs", {select1, busDrive1, done1, err1, ready1}, 32'd0);
        checkEq("abort_load_en", 32'(loadEn1), 32'd0);
        checkEq("abort_count", 32'(count1), 32'd0);
        clear = 1'b0;
        tick();
        checkEq("abort_ready", 32'(ready1), 32'd1);
        checkEq("abort_no_load", 32'(loadEn1), 32'd0);

        // Back-to-back: R1 -> R2, then R2 -> HI with req held throughout
        req1 = 1'b1; src1 = 24'h1 << 1; dst1 = 24'h1 << 2;
        sb1.push_back('{sel: 5'd1, mask: 24'h000004});
        sb1.push_back('{sel: 5'd2, mask: 24'h010000});
        tick();
        src1 = 24'h1 << 2; dst1 = 24'h1 << 16;
        checkEq("b2b_first_select", 32'(select1), 32'd1);
        tick();
        checkEq("b2b_first_load", 32'(loadEn1), 32'h000004);
        tick();
        checkEq("b2b_ready_returns", 32'(ready1), 32'd1);
        tick();
        checkEq("b2b_second_select", 32'(select1), 32'd2);
        checkEq("b2b_second_drive", 32'(busDrive1), 32'd1);
        tick();
        checkEq("b2b_second_load", 32'(loadEn1), 32'h010000);
        req1 = 1'b0;
        tick();
        checkEq("b2b_count", 32'(count1), 32'd2);
        tick();
        tick();
        checkEq("b2b_no_extra", {busDrive1, 16'(count1)}, 32'd2);

        // Three-cycle settle window: ZLOW -> R3 | R7
        req3 = 1'b1; src3 = 24'h1 << 19; dst3 = 24'h000088;
        sb3.push_back('{sel: 5'd19, mask: 24'h000088});
        tick();
        req3 = 1'b0; src3 = 24'h1; dst3 = 24'h1;
        for (int k = 1; k <= 4; k++) begin
            checkEq($sformatf("s3_c%0d_select", k), 32'(select3), 32'd19);
            checkEq($sformatf("s3_c%0d_bus", k), 32'(busDrive3), 32'd1);
            checkEq($sformatf("s3_c%0d_load_en", k), 32'(loadEn3), (k == 4) ? 32'h88 : 32'h0);
            tick();
        end
        checkEq("s3_bus_released", 32'(busDrive3), 32'd0);
        checkEq("s3_ready", 32'(ready3), 32'd1);
        checkEq("s3_count", 32'(count3), 32'd1);

        checkEq("sb1_drained", 32'(sb1.size()), 32'd0);
        checkEq("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/bus_drive_ctrl.md
Name: bus_drive_ctrl

Overview:
- Source/destination side of the 32-bit datapath bus: turns a one-hot "source out" request and a one-hot "destination in" request into the 5-bit bus select code, holds it for a settle window, then pulses the destination load enables.
- Sits between the control sequencer and the 32:1 bus multiplexer / register load enables.
- Single-transfer handshake; illegal requests are rejected.

Parameters:
- SETTLE_CYCLES, 1, cycles the select is held with bus_drive high before the load pulse; legal range 1..15.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- req  in  1  transfer request; accepted when req && ready
- src_out  in  24  one-hot source select, bit i = bus code i
- dst_in  in  24  destination load mask, same indexing
- ready  out  1  high only in IDLE with clear low
- select  out  5  bus mux select code
- bus_drive  out  1  select is valid and being driven
- load_en  out  24  one-cycle destination load strobes
- done  out  1  one-cycle pulse on the load cycle
- err  out  1  one-cycle pulse for a rejected request
- xfer_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- Bus code map (fixed):
  - 0..15 = R0..R15
  - 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLOW
  - 20 = PC, 21 = MDR, 22 = InPort, 23 = C_sign_extended
  - Codes 24..31 are never emitted.
- Reset (clear high at an edge):
  - state = IDLE.
  - select = 0, bus_drive = 0, load_en = 0, done = 0, err = 0, xfer_count = 0.
  - ready = 0 while clear is high; ready = 1 on the first cycle after clear drops.
  - This applies mid-transfer too: the load pulse for an aborted transfer is never issued.
- States are IDLE, DRIVE and LOAD. All outputs are registered.
- Accept check in IDLE at edge T with req = 1:
  - Legal: src_out has exactly one bit set; dst_in is nonzero; dst_in bits 22 and 23 are 0 (read-only sources).
  - Legal request: latch the src code and dst mask. At T+1: state = DRIVE, select = code, bus_drive = 1, ready = 0. Load the settle counter with SETTLE_CYCLES-1.
  - Illegal request: err = 1 for cycle T+1 only; state stays IDLE; ready stays 1; select and outputs are unchanged; xfer_count is unchanged.
- DRIVE:
  - Hold select; bus_drive = 1.
  - Decrement the counter each cycle. When the counter is 0 at an edge, go to LOAD.
  - bus_drive is therefore high for exactly SETTLE_CYCLES cycles before LOAD.
- LOAD (exactly one cycle, starting at cycle T+SETTLE_CYCLES+1):
  - load_en = latched dst mask; done = 1; select held; bus_drive = 1.
  - xfer_count increments at the end of this cycle.
  - Next state is IDLE with load_en = 0, done = 0, bus_drive = 0, ready = 1.
- select retains its last driven value while idle and only changes on acceptance.
- Multiple destination bits are allowed (broadcast).
- src bit equal to a dst bit is legal (self-transfer).
- req while ready = 0 is ignored; it is not queued.
- Back-to-back requests: a request can be accepted in the first IDLE cycle after LOAD.
  - Throughput is 1 transfer per SETTLE_CYCLES+2 cycles.
- Changes to src_out/dst_in after acceptance have no effect on the transfer in flight.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset then idle, SETTLE_CYCLES = 1: all outputs 0; ready = 1 one cycle after clear falls; xfer_count = 0.
- Legal transfer src_out = 1<<20 (PC), dst_in = 1<<21 (MDR), accepted at T:
  - select = 20 and bus_drive = 1 at T+1.
  - load_en = 0x200000 and done = 1 at T+2.
  - ready = 1 at T+3; xfer_count = 1.
- Rejects:
  - src_out = 0x000003 (two-hot) -> err pulse at T+1, no bus_drive, ready stays 1.
  - src_out = 1<<5 with dst_in = 1<<23 -> err.
  - src_out = 1<<5 with dst_in = 0 -> err.
- SETTLE_CYCLES = 3, src = ZLOW (bit 19), dst = R3 | R7:
  - select = 19 for 4 cycles.
  - bus_drive high 4 cycles (3 DRIVE + LOAD).
  - load_en = 0x000088 only in the 4th cycle.
- Clear asserted during DRIVE -> next cycle everything is 0 and load_en never pulses; a new request after clear completes normally.
- Two back-to-back legal requests (R1 -> R2, then R2 -> HI):
  - Second is accepted the cycle ready returns.
  - select sequence 1 then 2.
  - load_en pulses 0x4 then 0x10000.
  - xfer_count = 2.
  - A req held during DRIVE causes no extra transfer.
